lab06_result_buffer: RTL and testbench
======================================

# lab06_result_buffer

Downstream stage for the lab06 arithmetic unit: captures each signed 7-bit result it emits (`in_valid`/`in_result`), buffers results in a small FIFO, and releases them to a consumer over a valid/ready handshake. In parallel it keeps running statistics over all received results: count, saturating sum, minimum and maximum. It sits between the arithmetic unit's `out_valid`/`out_result` pins and the display/check logic.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `SUM_W`, 10: signed width of the running sum.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, **synchronous, active-high**.
- `in_valid` input 1: a result is present this cycle. There is no backpressure toward upstream.
- `in_result` input 7: signed result, -64..63.
- `stat_clear` input 1: clear the statistics; FIFO contents are unaffected.
- `out_ready` input 1: the consumer accepts `out_data` this cycle.
- `out_valid` output 1: FIFO is non-empty.
- `out_data` output 7: signed FIFO head.
- `full` output 1: FIFO holds `DEPTH` entries.
- `overflow` output 1: sticky; a result was dropped.
- `res_count` output 8: results received, saturating at 255.
- `res_sum` output `SUM_W`: signed running sum, saturating.
- `res_min` output 7: signed minimum result received.
- `res_max` output 7: signed maximum result received.

## Operation
- **FIFO storage**
  - Register array of `DEPTH` entries.
  - Write pointer, read pointer and occupancy counter (0..`DEPTH`).
  - `out_data` is always the head entry, i.e. a combinational read of registered storage.
- **Push**: a result is pushed when `in_valid` is high and either of these holds:
  - occupancy is below `DEPTH`; or
  - a pop happens in the same cycle (`out_valid && out_ready`).
- **Pop**: occurs when `out_valid && out_ready`.
- **Pointers and occupancy**
  - Pointers wrap modulo `DEPTH`.
  - Push and pop in the same cycle: occupancy is unchanged, both pointers advance.
  - Pop when empty: impossible, because `out_valid` is 0.
- **Drop**
  - `in_valid` while full with no pop: the result is discarded and `overflow` is set to 1.
  - `overflow` stays 1 until `rst`.
  - FIFO state is unchanged by a drop.
- **Statistics cover every `in_valid` result, including dropped ones.**
  - `res_count` increments and holds at 255.
  - `res_sum` = sign-extended sum clamped to [-2^(SUM_W-1), 2^(SUM_W-1)-1]. At the default width that is [-512, 511].
  - Once saturated, the sum still moves off the rail when a result of the opposite sign arrives.
- **Minimum and maximum**
  - First result after reset or clear: `res_min` = `res_max` = that result.
  - Afterwards they update on signed comparison.
  - While `res_count` = 0, min and max read 0.
- **`stat_clear`**
  - The next cycle's count, sum, min and max are 0.
  - If `in_valid` is high in the same cycle, the clear takes priority and the statistics then reflect only that result: count 1, sum = min = max = result.

## Timing
- **Reset**: `rst` high at a clock edge sets:
  - occupancy and both pointers to 0;
  - `out_valid` 0, `full` 0, `overflow` 0;
  - count, sum, min and max to 0.
- **Mid-operation reset**
  - Discards all buffered data.
  - Any `in_valid` in the reset cycle is ignored.
  - Storage contents need not be cleared, but `out_data` is don't-care while `out_valid` = 0.
- **Latency**
  - Result pushed into an empty FIFO at edge N: `out_valid` = 1 and `out_data` = result from edge N onward. There is no bypass.
  - Statistics change at the same edge as the `in_valid` sample.
- **Handshake**: while `out_valid` = 1 and `out_ready` = 0, `out_data` must remain stable.
- **Status**: `full` and `out_valid` derive from registered occupancy and never glitch within a cycle.
- **Back-to-back**: one push and one pop per cycle are sustainable indefinitely. This matches the upstream ability to assert `in_valid` on consecutive cycles.

## Test plan
- **Ordering**
  - Stimulus: after reset, push 5, -3, 63 on consecutive cycles with `out_ready` = 0, then raise `out_ready`.
  - Required: `out_data` = 5, -3, 63 on three successive cycles, then `out_valid` = 0.
  - Required: count = 3, sum = 65, min = -3, max = 63.
- **Overflow and full**
  - Stimulus: `DEPTH` = 4, `out_ready` = 0, push 1, 2, 3, 4, 5.
  - Required: `full` = 1 after the 4th push, `overflow` = 1 after the 5th.
  - Required: drain yields 1, 2, 3, 4.
  - Required: count = 5, sum = 15.
- **Push with pop at full**
  - Stimulus: FIFO full with 1, 2, 3, 4; assert `in_valid` with 9 and `out_ready` in the same cycle.
  - Required: pops 1 and accepts 9, `overflow` stays 0, `full` stays 1.
  - Required: drain order 2, 3, 4, 9.
- **Sum saturation**
  - Stimulus: nine results of 63 (`SUM_W` = 10).
  - Required: `res_sum` = 511 after the 9th (567 clamped).
  - Stimulus: then -64.
  - Required: `res_sum` = 447.
  - Stimulus: ten results of -64 from clear.
  - Required: `res_sum` = -512.
- **Clear with a simultaneous result**
  - Stimulus: after results 10 and -20, assert `stat_clear` with `in_valid` = -7.
  - Required: count = 1, sum = min = max = -7.
  - Required: FIFO still outputs 10, -20, -7.
- **Reset mid-stream**
  - Stimulus: assert `rst` with 2 entries buffered and `in_valid` high.
  - Required: next cycle `out_valid` = 0, `full` = 0, `overflow` = 0, all statistics 0.
  - Required: the result presented during reset never appears on `out_data`.

Source files
------------

// File: rtl/lab06_result_buffer.sv
// Result buffer behind the lab06 arithmetic unit: a small FIFO toward the consumer
// plus running count / saturating sum / min / max over every result seen.
module lab06_result_buffer #(
    parameter int DEPTH = 4,
    parameter int SUM_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [6:0]       in_result,
    input  logic                    stat_clear,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [6:0]       out_data,
    output logic                    full,
    output logic                    overflow,
    output logic [7:0]              res_count,
    output logic signed [SUM_W-1:0] res_sum,
    output logic signed [6:0]       res_min,
    output logic signed [6:0]       res_max
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic signed [6:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic               pop;
    logic               push;
    logic               drop;

    logic [7:0]              count_base;
    logic signed [SUM_W:0]   sum_base;
    logic signed [SUM_W:0]   res_ext;
    logic signed [SUM_W:0]   sum_wide;
    logic signed [SUM_W-1:0] sum_next;
    logic [7:0]              count_next;
    logic                    first;

    assign out_valid = (occ != '0);
    assign full      = (occ == OCC_FULL);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= in_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push) begin
                occ <= occ - OCC_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // One guard bit lets the add never wrap; disagreeing top bits mean clamp.
    always_comb begin
        count_base = stat_clear ? 8'd0 : res_count;
        sum_base   = stat_clear ? '0 : {res_sum[SUM_W-1], res_sum};
        res_ext    = {{(SUM_W-6){in_result[6]}}, in_result};
        sum_wide   = sum_base + res_ext;
        if (sum_wide[SUM_W] != sum_wide[SUM_W-1]) begin
            sum_next = sum_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}}
                                       : {1'b0, {(SUM_W-1){1'b1}}};
        end else begin
            sum_next = sum_wide[SUM_W-1:0];
        end
        count_next = (count_base == 8'hFF) ? count_base : count_base + 8'd1;
        first      = (count_base == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_count <= 8'd0;
            res_sum   <= '0;
            res_min   <= '0;
            res_max   <= '0;
        end else if (in_valid) begin
            res_count <= count_next;
            res_sum   <= sum_next;
            res_min   <= (first || (in_result < res_min)) ? in_result : res_min;
            res_max   <= (first || (in_result > res_max)) ? in_result : res_max;
        end else if (stat_clear) begin
            res_count <= 8'd0;
            res_sum   <= '0;
            res_min   <= '0;
            res_max   <= '0;
        end
    end

endmodule

// File: tb/tb_lab06_result_buffer.sv
// Self-checking bench for lab06_result_buffer: vector table plus hand sequences,
// with a scoreboard queue tracking the expected FIFO contents.
module tb_lab06_result_buffer;

    localparam int DEPTH   = 4;
    localparam int SUM_W   = 10;
    localparam int SUM_MAX = 511;
    localparam int SUM_MIN = -512;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [6:0]       in_result;
    logic                    stat_clear;
    logic                    out_ready;
    logic                    out_valid;
    logic signed [6:0]       out_data;
    logic                    full;
    logic                    overflow;
    logic [7:0]              res_count;
    logic signed [SUM_W-1:0] res_sum;
    logic signed [6:0]       res_min;
    logic signed [6:0]       res_max;

    lab06_result_buffer #(.DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
        .stat_clear(stat_clear), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .full(full), .overflow(overflow),
        .res_count(res_count), .res_sum(res_sum), .res_min(res_min), .res_max(res_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int iv; int res; int clr; int rdy;
        int count; int sum; int mn; int mx; int full; int ovf;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    int q[$];
    int m_count, m_sum, m_min, m_max, m_ovf;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkStats(input string tag, input int c, input int s, input int mn, input int mx);
        checkOutput({tag, "_count"}, int'(res_count), c);
        checkOutput({tag, "_sum"}, int'(res_sum), s);
        checkOutput({tag, "_min"}, int'(res_min), mn);
        checkOutput({tag, "_max"}, int'(res_max), mx);
    endtask

    // One clock: drive inputs, score the pre-edge head, update the model, check post-edge state.
    task automatic applyStimulus(input int iv, input int r, input int clr, input int rdy);
        bit pop_m, push_m, first;
        int s;
        in_valid   = (iv != 0);
        in_result  = 7'(r);
        stat_clear = (clr != 0);
        out_ready  = (rdy != 0);
        @(negedge clk);
        checkOutput("out_valid", int'(out_valid), int'(q.size() > 0));
        if (q.size() > 0) checkOutput("out_data", int'(out_data), q[0]);
        pop_m  = (q.size() > 0) && (rdy != 0);
        push_m = (iv != 0) && ((q.size() < DEPTH) || pop_m);
        if ((iv != 0) && !push_m) m_ovf = 1;
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(r);
        if (clr != 0) begin
            m_count = 0; m_sum = 0; m_min = 0; m_max = 0;
        end
        if (iv != 0) begin
            first = (m_count == 0);
            if (m_count < 255) m_count++;
            s = m_sum + r;
            m_sum = (s > SUM_MAX) ? SUM_MAX : (s < SUM_MIN) ? SUM_MIN : s;
            if (first || r < m_min) m_min = r;
            if (first || r > m_max) m_max = r;
        end
        @(posedge clk);
        #1;
        checkOutput("full", int'(full), int'(q.size() == DEPTH));
        checkOutput("overflow", int'(overflow), m_ovf);
        checkStats("model", m_count, m_sum, m_min, m_max);
    endtask

    task automatic doReset(input int iv, input int r);
        rst = 1'b1; in_valid = (iv != 0); in_result = 7'(r);
        stat_clear = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        m_count = 0; m_sum = 0; m_min = 0; m_max = 0; m_ovf = 0;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_full", int'(full), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkStats("rst", 0, 0, 0, 0);
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1,  5, 0, 0, 1,  5,  5,  5, 0, 0};
        vecs[1]  = '{1, -3, 0, 0, 2,  2, -3,  5, 0, 0};
        vecs[2]  = '{1, 63, 0, 0, 3, 65, -3, 63, 0, 0};
        vecs[3]  = '{0,  0, 0, 1, 3, 65, -3, 63, 0, 0};
        vecs[4]  = '{0,  0, 0, 1, 3, 65, -3, 63, 0, 0};
        vecs[5]  = '{0,  0, 0, 1, 3, 65, -3, 63, 0, 0};
        vecs[6]  = '{0,  0, 0, 1, 3, 65, -3, 63, 0, 0};
        vecs[7]  = '{0,  0, 1, 0, 0,  0,  0,  0, 0, 0};
        vecs[8]  = '{1,  1, 0, 0, 1,  1,  1,  1, 0, 0};
        vecs[9]  = '{1,  2, 0, 0, 2,  3,  1,  2, 0, 0};
        vecs[10] = '{1,  3, 0, 0, 3,  6,  1,  3, 0, 0};
        vecs[11] = '{1,  4, 0, 0, 4, 10,  1,  4, 1, 0};
        vecs[12] = '{1,  5, 0, 0, 5, 15,  1,  5, 1, 1};
        vecs[13] = '{0,  0, 0, 1, 5, 15,  1,  5, 0, 1};
        vecs[14] = '{0,  0, 0, 1, 5, 15,  1,  5, 0, 1};
        vecs[15] = '{0,  0, 0, 1, 5, 15,  1,  5, 0, 1};
        vecs[16] = '{0,  0, 0, 1, 5, 15,  1,  5, 0, 1};

        rst = 1'b1; in_valid = 1'b0; in_result = '0; stat_clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        doReset(0, 0);

        // Ordering, then fill / drop / drain; data order is scored by the queue.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].res, vecs[i].clr, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_full", i), int'(full), vecs[i].full);
            checkOutput($sformatf("vec%0d_ovf", i), int'(overflow), vecs[i].ovf);
            checkStats($sformatf("vec%0d", i), vecs[i].count, vecs[i].sum, vecs[i].mn, vecs[i].mx);
        end
        checkOutput("drained_out_valid", int'(out_valid), 0);

        // Push with pop while full.
        doReset(0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(1, i, 0, 0);
        checkOutput("pf_full_before", int'(full), 1);
        applyStimulus(1, 9, 0, 1);
        checkOutput("pf_full_after", int'(full), 1);
        checkOutput("pf_overflow", int'(overflow), 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("pf_empty", int'(out_valid), 0);

        // Sum saturation at both rails.
        doReset(0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1, 63, 0, 1);
        checkOutput("sat_hi", int'(res_sum), 511);
        applyStimulus(1, -64, 0, 1);
        checkOutput("sat_off_hi", int'(res_sum), 447);
        applyStimulus(0, 0, 1, 1);
        checkStats("sat_clear", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, -64, 0, 1);
        checkOutput("sat_lo", int'(res_sum), -512);
        checkOutput("sat_lo_count", int'(res_count), 10);
        applyStimulus(1, 5, 0, 1);
        checkOutput("sat_off_lo", int'(res_sum), -507);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);

        // Clear together with a result.
        doReset(0, 0);
        applyStimulus(1, 10, 0, 0);
        applyStimulus(1, -20, 0, 0);
        applyStimulus(1, -7, 1, 0);
        checkStats("clr_sim", 1, -7, -7, -7);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1);

        // Reset mid-stream with overflow set and a result presented during reset.
        doReset(0, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(1, 10 * i, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1);
        checkOutput("mid_ovf_set", int'(overflow), 1);
        doReset(1, 33);
        applyStimulus(1, -1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("mid_empty", int'(out_valid), 0);

        // Count saturation under sustained push+pop.
        doReset(0, 0);
        for (int i = 0; i < 260; i++) applyStimulus(1, (i % 128) - 64, 0, 1);
        checkOutput("cnt_sat", int'(res_count), 255);
        checkOutput("cnt_min", int'(res_min), -64);
        checkOutput("cnt_max", int'(res_max), 63);
        checkOutput("cnt_ovf", int'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
